// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD score converter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;

  // Largest value representable with num_hex decimal digits (10^n - 1).
  function automatic longint unsigned max_bcd_value(input int num_hex);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < num_hex; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction cell: add 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= BCD_DIGIT_W'(5)) begin
      adj = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter; bcd/ovf hold the last result.
// Latency: start accepted at cycle t -> done pulse and new bcd at t+BIN_W+1.
// Backpressure: start is ignored while busy; optional BIN2BCD_AUTO_START_EN starts on bin change.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W   = 10,
  parameter int NUM_HEX = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BIN_W-1:0]               bin,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_HEX*BCD_DIGIT_W-1:0] bcd,
  output logic                           ovf
);

  localparam int BCD_W = NUM_HEX * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CMP_W = (BIN_W + 1 > 64) ? BIN_W + 1 : 64;
  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(max_bcd_value(NUM_HEX));

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic [CNT_W-1:0] count;
  logic             ovf_pend;
  logic             trig;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit (scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (scratch_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Carry out of the top digit is dropped; it only occurs on overflow, which is masked.
  assign scratch_nxt = BCD_W'({scratch_adj, shreg[BIN_W-1]});

`ifdef BIN2BCD_AUTO_START_EN
  logic [BIN_W-1:0] last_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_bin <= '0;
    end else if (trig && (state != SHIFT)) begin
      last_bin <= bin;
    end
  end

  assign trig = start | (bin != last_bin);
`else
  assign trig = start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (trig) begin
            shreg    <= bin;
            scratch  <= '0;
            count    <= '0;
            ovf_pend <= CMP_W'(bin) > MAX_VAL;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          count   <= count + CNT_W'(1);
          if (count == CNT_W'(BIN_W - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= ovf_pend ? {NUM_HEX{4'h9}} : scratch_nxt;
            ovf   <= ovf_pend;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
